// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder; define SERIAL_ADDER_SUB_EN to add a sub port for A-B.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, co_q, co_d, busy_q, busy_d, done_q, done_d;
  logic sub_w, h1_s, h1_c, h2_c, bit_s, c_next, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif
  assign h1_s   = a_q[0] ^ b_q[0];
  assign h1_c   = a_q[0] & b_q[0];
  assign bit_s  = h1_s ^ c_q;
  assign h2_c   = h1_s & c_q;
  assign c_next = h1_c | h2_c;
  assign last   = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub_w ? ~b : b;
      c_d     = sub_w;
      r_d     = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      c_d     = c_next;
      r_d     = {bit_s, r_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? DONE : RUN;
      sum_d   = last ? r_d : sum_q;
      co_d    = last ? c_next : co_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_q == RUN;
    done_d = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = co_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n, start, sub;
  logic [7:0] a, b, sum;
  logic busy, done, carry_out;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .carry_out(carry_out)
  );

  // mode 0: plain op, 1: extra start mid-RUN, 2: reset pulse in 4th RUN cycle
  task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                    input logic [7:0] es, input logic ec, input int mode, input string nm);
    int nb, nd, dk;
    nb = 0; nd = 0; dk = -1;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (busy && done) begin
        n_cmp++; n_bad++;
        $display("FAIL %s busy_and_done k=%0d", nm, k);
      end
      if (done) begin
        nd++; dk = k;
        n_cmp++;
        if (sum !== es || carry_out !== ec) begin
          n_bad++;
          $display("FAIL %s result got=%h/%b want=%h/%b", nm, sum, carry_out, es, ec);
        end
      end
      if (k == 0) begin start = 1'b0; a = ~ta; b = ~tb_v; sub = ~ts; end
      if (mode == 1 && k == 3) begin start = 1'b1; a = 8'h11; b = 8'h11; end
      if (mode == 1 && k == 4) start = 1'b0;
      if (mode == 2 && k == 3) rst_n = 1'b0;
      if (mode == 2 && k == 4) rst_n = 1'b1;
    end
    if (mode != 2) begin
      n_cmp++;
      if (dk !== 9) begin n_bad++; $display("FAIL %s done_latency got=%0d want=9", nm, dk); end
      n_cmp++;
      if (nd !== 1) begin n_bad++; $display("FAIL %s done_count got=%0d want=1", nm, nd); end
      n_cmp++;
      if (nb !== 8) begin n_bad++; $display("FAIL %s busy_cycles got=%0d want=8", nm, nb); end
      n_cmp++;
      if (sum !== es || carry_out !== ec) begin
        n_bad++;
        $display("FAIL %s hold got=%h/%b want=%h/%b", nm, sum, carry_out, es, ec);
      end
    end else begin
      n_cmp++;
      if (nd !== 0) begin n_bad++; $display("FAIL %s done_after_reset got=%0d want=0", nm, nd); end
      n_cmp++;
      if (sum !== 8'h00 || carry_out !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s reset_clear got=%h/%b busy=%b want=00/0 busy=0", nm, sum, carry_out, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h co=%b want 0/0/00/0", busy, done, sum, carry_out);
    end
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_priority busy got=%b want=0", busy); end
  endtask

  task automatic test_add;
    op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, "add_35_4a");
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "add_ff_01");
    op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, "add_80_80");
    op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, "add_a5_5a");
  endtask

  task automatic test_mid_start;
    op(8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1, "mid_start_orig");
    op(8'h11, 8'h11, 1'b0, 8'h22, 1'b0, 0, "mid_start_next");
  endtask

  task automatic test_mid_reset;
    op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 2, "mid_reset");
    op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, "after_reset");
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    op(8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 0, "sub_10_03");
    op(8'h03, 8'h10, 1'b1, 8'hF3, 1'b0, 0, "sub_03_10");
    op(8'h42, 8'h42, 1'b1, 8'h00, 1'b1, 0, "sub_42_42");
    op(8'h10, 8'h03, 1'b0, 8'h13, 1'b0, 0, "sub0_add");
  endtask
`endif

  task automatic test_back_to_back;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vs [3];
    logic       vc [3];
    int nd, i, j;
    va = '{8'h12, 8'hF0, 8'hAA};
    vb = '{8'h34, 8'h20, 8'h55};
    vs = '{8'h46, 8'h10, 8'hFF};
    vc = '{1'b0, 1'b1, 1'b0};
    nd = 0;
    @(negedge clk);
    a = va[0]; b = vb[0]; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      i = k / 10; j = k % 10;
      if (done) begin
        nd++;
        n_cmp++;
        if (j !== 9 || sum !== vs[i] || carry_out !== vc[i]) begin
          n_bad++;
          $display("FAIL b2b_op%0d got slot=%0d res=%h/%b want slot=9 res=%h/%b", i, j, sum, carry_out, vs[i], vc[i]);
        end
      end
      if (j == 0 && i < 2) begin a = va[i+1]; b = vb[i+1]; end
      if (j == 0 && i == 2) start = 1'b0;
    end
    n_cmp++;
    if (nd !== 3) begin n_bad++; $display("FAIL b2b_done_count got=%0d want=3", nd); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mid_start();
    test_mid_reset();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN; captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse when sum/carry_out become valid.
REQ-010 sum  output  WIDTH  result; held stable from done until next accepted start.
REQ-011 carry_out  output  1  final carry; held with sum.

Function
REQ-012 FSM states: IDLE, RUN, DONE; encoding free.
REQ-013 IDLE -> RUN when start=1; a, b, and sub are loaded into internal shift registers, carry flip-flop cleared (or set, see REQ-026), bit counter cleared.
REQ-014 IDLE with start=0: no state change; sum and carry_out hold.
REQ-015 RUN: one bit per cycle, LSB first; bit sum = a0 ^ b0 ^ c, next carry = (a0 & b0) | (c & (a0 ^ b0)), built as two half-adder stages plus OR.
REQ-016 RUN: operand registers shift right by one; the result bit enters the result register MSB and the result register shifts right, so after WIDTH shifts bit 0 is the first computed bit.
REQ-017 RUN -> DONE after exactly WIDTH bit cycles (counter reaches WIDTH-1 on the last bit).
REQ-018 DONE: done=1 for exactly one cycle; sum/carry_out valid; unconditional transition to IDLE next cycle.
REQ-019 Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH+1; the next start is accepted no earlier than edge N+WIDTH+2.
REQ-020 start while in RUN or DONE is ignored, with no queuing.
REQ-021 a, b, and sub changing after acceptance have no effect on the current operation.
REQ-022 busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both high.
REQ-023 sum and the visible carry_out update only on the RUN->DONE edge; intermediate bits are not visible on sum.
REQ-024 Arithmetic is modulo 2^WIDTH; overflow appears only in carry_out (e.g. all-ones + 1 -> sum 0, carry_out 1).

Reset
REQ-025 rst_n=0 at a rising edge: state IDLE, busy=0, done=0, sum=0, carry_out=0, internal carry/counter/shift registers=0; this applies in any state, including mid-RUN (operation abandoned, no done pulse) and during DONE (pulse cut short); reset takes priority over start in the same cycle.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN defined: sub port exists; with sub=1, B is inverted at load and the carry flip-flop initialised to 1, giving sum = A - B mod 2^WIDTH and carry_out = 1 when A >= B (no borrow); sub=0 behaves as add.
REQ-027 Macro SERIAL_ADDER_SUB_EN undefined: no sub port; carry initialised to 0; addition only; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 Reset, then start with a=0x35, b=0x4A -> done pulse 9 cycles after the accept edge, with sum=0x7F, carry_out=0, and busy high for 8 cycles.
REQ-029 a=0xFF, b=0x01 -> sum=0x00, carry_out=1; a=0x80, b=0x80 -> sum=0x00, carry_out=1.
REQ-030 start pulsed again mid-RUN with a=0x11, b=0x11 -> ignored; the original result is delivered, exactly one done pulse, then the new start is accepted from IDLE.
REQ-031 rst_n low for one cycle during the 4th RUN cycle -> IDLE, sum=0, carry_out=0, and no done pulse; a following start with a=0x0F, b=0x01 -> sum=0x10.
REQ-032 With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x03 -> sum=0x0D, carry_out=1; sub=1, a=0x03, b=0x10 -> sum=0xF3, carry_out=0.
REQ-033 Back-to-back: start held high continuously -> operations accepted every WIDTH+2 cycles, with each done pulse matching the operands present at its accept edge.
